apb_reg_write_arbiter: RTL
==========================

// Module: apb_reg_write_arbiter
// PURPOSE
//  Shares the single write port of the 8-entry APB register bank between the APB
//  slave (port A) and the accelerator engine (port B). Each port has a one-entry
//  holding buffer, so a losing write is never dropped. A round-robin or fixed-priority
//  arbiter issues at most one registered write per cycle to the bank.
// PARAMETERS
//  APB_DATA_WIDTH  32  width of write data
//  REG_NUM         8   registers in bank; address width AW = $clog2(REG_NUM)
//  FIXED_PRIO      0   0: round-robin; 1: port A always wins
//  CNT_WIDTH       16  width of the saturating conflict counter
// PORTS
//  clk           in   1               clock, rising edge
//  reset         in   1               asynchronous, active-high reset
//  a_valid       in   1               port A write request
//  a_ready       out  1               port A can accept this cycle
//  a_addr        in   AW              port A register index
//  a_wdata       in   APB_DATA_WIDTH  port A write data
//  b_valid       in   1               port B write request
//  b_ready       out  1               port B can accept this cycle
//  b_addr        in   AW              port B register index
//  b_wdata       in   APB_DATA_WIDTH  port B write data
//  reg_wen       out  1               write strobe to register bank
//  reg_addr      out  AW              write index to register bank
//  reg_wdata     out  APB_DATA_WIDTH  write data to register bank
//  busy          out  1               any holding buffer occupied, or reg_wen high
//  conflict_cnt  out  CNT_WIDTH       cycles in which both buffers were pending
// BEHAVIOUR
//  - Reset (async, any time): clear both buffers, set rr_ptr to A, and clear
//    reg_wen/reg_addr/reg_wdata/conflict_cnt to 0. Buffered writes are discarded.
//  - Buffers:
//    - Each port has a pend flag, an addr register and a data register.
//    - A transfer occurs when valid & ready at a rising edge. It loads the buffer
//      and sets pend.
//  - Grant (combinational):
//    - Computed only from the pend flags and rr_ptr, never from valid.
//    - If only one port is pending, that port is granted.
//    - If both are pending, the port named by rr_ptr is granted. With FIXED_PRIO=1,
//      port A is granted.
//  - Ready:
//    - x_ready = ~x_pend | grant_x. A new write may refill a buffer in the same
//      cycle it drains, so each port sustains 1 write/cycle when uncontended.
//  - Pend update at the edge:
//    - Cleared if granted and no new transfer.
//    - Held set if granted and a new transfer arrives.
//  - rr_ptr: after any grant it points to the non-granted port. It is unchanged
//    when nothing is granted and unused when FIXED_PRIO=1.
//  - Output:
//    - On the edge after a grant: reg_wen=1, and reg_addr/reg_wdata take the
//      granted buffer contents.
//    - Otherwise: reg_wen=0, and reg_addr/reg_wdata hold their last values.
//    - Latency: a transfer at edge N gives grant in cycle N..N+1 and reg_wen high
//      for exactly one cycle after edge N+1 (best case 2 edges).
//  - Contention:
//    - Round-robin: both ports continuously pending alternate A,B,A,B...
//    - Worst-case wait is one extra cycle.
//    - Fixed priority: B may starve while A streams.
//  - Same address from both ports: both writes are issued in grant order; the bank
//    keeps the later one. No merging or dropping.
//  - conflict_cnt increments on every cycle with a_pend & b_pend. It saturates at
//    all-ones and never wraps.
//  - All register indices are in range (AW bits); no error response exists.
// TESTING
//  1. Single A write:
//     - Stimulus: a_valid=1 for 1 cycle, addr=3, data=0xDEADBEEF.
//     - Response: a_ready=1; reg_wen pulses 1 cycle, 2 edges later, addr=3,
//       data=0xDEADBEEF; busy returns 0.
//  2. Simultaneous single writes:
//     - Stimulus: A addr=1/0x11 and B addr=1/0x22, both after reset.
//     - Response: A issued first, then B on the next cycle; final write is 0x22;
//       conflict_cnt=1.
//  3. Round-robin streaming:
//     - Stimulus: both ports stream 4 writes each (A data 0xA0..0xA3, B data
//       0xB0..0xB3).
//     - Response: reg_wdata sequence is A0,B0,A1,B1,A2,B2,A3,B3; no write lost;
//       ready stalls respected.
//  4. FIXED_PRIO=1:
//     - Stimulus: A streams 5 writes while B holds 1 pending.
//     - Response: B is issued only after A stops; b_ready stays 0 meanwhile.
//  5. Reset mid-operation:
//     - Stimulus: assert reset while both buffers are pending.
//     - Response: outputs go to 0 immediately; no reg_wen after release; rr_ptr=A.
//  6. Saturation:
//     - Stimulus: CNT_WIDTH=4, hold both ports contended for 20 cycles.
//     - Response: conflict_cnt stops at 15.

Source files
------------

// File: rtl/apb_reg_write_arbiter.sv
// Arbitrates the single write port of the register bank between the APB slave
// (port A) and the accelerator (port B), each fronted by a one-entry holding buffer.
module apb_reg_write_arbiter #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int REG_NUM        = 8,
  parameter bit FIXED_PRIO     = 1'b0,
  parameter int CNT_WIDTH      = 16,
  localparam int AW            = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [AW-1:0]             a_addr,
  input  logic [APB_DATA_WIDTH-1:0] a_wdata,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [AW-1:0]             b_addr,
  input  logic [APB_DATA_WIDTH-1:0] b_wdata,
  output logic                      reg_wen,
  output logic [AW-1:0]             reg_addr,
  output logic [APB_DATA_WIDTH-1:0] reg_wdata,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      conflict_cnt
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                      a_pend_q, a_pend_d;
  logic [AW-1:0]             a_addr_q, a_addr_d;
  logic [APB_DATA_WIDTH-1:0] a_data_q, a_data_d;
  logic                      b_pend_q, b_pend_d;
  logic [AW-1:0]             b_addr_q, b_addr_d;
  logic [APB_DATA_WIDTH-1:0] b_data_q, b_data_d;
  port_e                     rr_q, rr_d;
  logic                      wen_q, wen_d;
  logic [AW-1:0]             waddr_q, waddr_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  logic grant_a_s, grant_b_s;
  logic a_xfer_s, b_xfer_s;
  logic both_pend_s;

  assign both_pend_s = a_pend_q & b_pend_q;

  // Grant looks only at buffered requests, so a fresh valid never bypasses a waiting buffer.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (both_pend_s) begin
      if (FIXED_PRIO || (rr_q == PORT_A)) begin
        grant_a_s = 1'b1;
      end else begin
        grant_b_s = 1'b1;
      end
    end else begin
      grant_a_s = a_pend_q;
      grant_b_s = b_pend_q;
    end
  end

  assign a_ready  = ~a_pend_q | grant_a_s;
  assign b_ready  = ~b_pend_q | grant_b_s;
  assign a_xfer_s = a_valid & a_ready;
  assign b_xfer_s = b_valid & b_ready;

  // Holding buffers: a draining buffer may be refilled in the same cycle.
  always_comb begin
    a_pend_d = a_pend_q;
    a_addr_d = a_addr_q;
    a_data_d = a_data_q;
    b_pend_d = b_pend_q;
    b_addr_d = b_addr_q;
    b_data_d = b_data_q;
    if (a_xfer_s) begin
      a_pend_d = 1'b1;
      a_addr_d = a_addr;
      a_data_d = a_wdata;
    end else if (grant_a_s) begin
      a_pend_d = 1'b0;
    end else begin
      a_pend_d = a_pend_q;
    end
    if (b_xfer_s) begin
      b_pend_d = 1'b1;
      b_addr_d = b_addr;
      b_data_d = b_wdata;
    end else if (grant_b_s) begin
      b_pend_d = 1'b0;
    end else begin
      b_pend_d = b_pend_q;
    end
  end

  // Round-robin pointer hands priority to whichever port lost the last grant.
  always_comb begin
    rr_d = rr_q;
    case ({grant_a_s, grant_b_s})
      2'b10:   rr_d = PORT_B;
      2'b01:   rr_d = PORT_A;
      default: rr_d = rr_q;
    endcase
  end

  // Bank write port and saturating contention counter.
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (grant_a_s) begin
      wen_d   = 1'b1;
      waddr_d = a_addr_q;
      wdata_d = a_data_q;
    end else if (grant_b_s) begin
      wen_d   = 1'b1;
      waddr_d = b_addr_q;
      wdata_d = b_data_q;
    end else begin
      wen_d   = 1'b0;
    end
    if (both_pend_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards any buffered writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_pend_q <= 1'b0;
      a_addr_q <= {AW{1'b0}};
      a_data_q <= {APB_DATA_WIDTH{1'b0}};
      b_pend_q <= 1'b0;
      b_addr_q <= {AW{1'b0}};
      b_data_q <= {APB_DATA_WIDTH{1'b0}};
      rr_q     <= PORT_A;
      wen_q    <= 1'b0;
      waddr_q  <= {AW{1'b0}};
      wdata_q  <= {APB_DATA_WIDTH{1'b0}};
      cnt_q    <= {CNT_WIDTH{1'b0}};
    end else begin
      a_pend_q <= a_pend_d;
      a_addr_q <= a_addr_d;
      a_data_q <= a_data_d;
      b_pend_q <= b_pend_d;
      b_addr_q <= b_addr_d;
      b_data_q <= b_data_d;
      rr_q     <= rr_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign reg_wen      = wen_q;
  assign reg_addr     = waddr_q;
  assign reg_wdata    = wdata_q;
  assign conflict_cnt = cnt_q;
  assign busy         = a_pend_q | b_pend_q | wen_q;

endmodule
